// File: rtl/soc_system_pio_edge.sv
// Avalon-MM PIO slave: output register with atomic set/clear, synchronised inputs,
// per-bit edge capture (W1C) and a maskable registered level interrupt.
module soc_system_pio_edge #(
    parameter int unsigned       WIDTH       = 10,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
    parameter int unsigned       EDGE_TYPE   = 0,
    parameter int unsigned       SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    typedef enum logic {
        BLANK,
        RUN
    } blank_state_t;

    localparam logic [2:0] BLANK_LAST = 3'(SYNC_STAGES);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] hist_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] cap_q;
    logic             irq_q;

    blank_state_t     state_q, state_nxt;
    logic [2:0]       cnt_q, cnt_nxt;
    logic             blank;

    logic             wr_en;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] sync_last;
    logic [WIDTH-1:0] edge_raw;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] w1c;
    logic             unused_wd;

    assign wr_en     = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign sync_last = sync_q[SYNC_STAGES-1];
    assign unused_wd = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Edge detection stays blanked until the synchroniser and history flop have
    // filled with real input values, so inputs high at reset do not capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BLANK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        blank     = 1'b0;
        case (state_q)
            BLANK: begin
                blank = 1'b1;
                if (cnt_q == BLANK_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + 3'd1;
                end
            end
            default: begin
                blank = 1'b0;
            end
        endcase
    end

    always_comb begin
        edge_raw = '0;
        case (EDGE_TYPE)
            0:       edge_raw = sync_last & ~hist_q;
            1:       edge_raw = ~sync_last & hist_q;
            default: edge_raw = sync_last ^ hist_q;
        endcase
        edge_det = blank ? '0 : edge_raw;
        w1c      = (wr_en && address == 3'd3) ? wd : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= '0;
            out_q  <= RESET_VALUE;
            mask_q <= '0;
            cap_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            hist_q <= sync_last;
            // A new edge takes priority over a same-cycle W1C of that bit.
            cap_q  <= (cap_q & ~w1c) | edge_det;
            irq_q  <= |(cap_q & mask_q);
            if (wr_en) begin
                case (address)
                    3'd0:    out_q  <= wd;
                    3'd2:    mask_q <= wd;
                    3'd4:    out_q  <= out_q | wd;
                    3'd5:    out_q  <= out_q & ~wd;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            3'd0:    readdata[WIDTH-1:0] = out_q;
            3'd1:    readdata[WIDTH-1:0] = sync_last;
            3'd2:    readdata[WIDTH-1:0] = mask_q;
            3'd3:    readdata[WIDTH-1:0] = cap_q;
            default: readdata = '0;
        endcase
    end

    assign out_port = out_q;
    assign irq      = irq_q;

endmodule

// File: doc/soc_system_pio_edge.md
Name: soc_system_pio_edge

Overview:
Parametrised Avalon-MM slave PIO that generalises the fixed-width output-only LED port. It provides a WIDTH-bit output register with atomic set/clear, a synchronised input port, per-bit edge capture and a maskable level interrupt. Each instance sits on the HPS lightweight bridge and drives board LEDs/GPIO or samples buttons/switches.

Parameters:
WIDTH, 10, number of output and input bits (1..32)
RESET_VALUE, 0, out_port value after reset (WIDTH bits)
EDGE_TYPE, 0, edge captured: 0 rising, 1 falling, 2 any
SYNC_STAGES, 2, input synchroniser depth (2..4)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  3  register word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data; bits above WIDTH ignored
readdata  out  32  read data, zero-extended above WIDTH
in_port  in  WIDTH  asynchronous external inputs
out_port  out  WIDTH  registered outputs
irq  out  1  level interrupt, active high

Behaviour:
- One clock, clk. reset_n is asynchronous assert, active low; all flops clear on reset_n=0 regardless of clk.
- Write occurs on the rising edge where chipselect=1 and write_n=0. Reads are combinational (0 wait states): readdata reflects the addressed register in the same cycle. Unmapped addresses read 0, and writes to them are ignored.
- Register map:
  - 0 DATA_OUT: RW, the out_port register.
  - 1 DATA_IN: RO, the synchronised input (last sync stage).
  - 2 IRQ_MASK: RW.
  - 3 EDGE_CAP: read returns the captures; writing 1 clears the bit (W1C), writing 0 has no effect.
  - 4 OUT_SET: WO, DATA_OUT |= wd. Reads 0.
  - 5 OUT_CLR: WO, DATA_OUT &= ~wd. Reads 0.
- Reset values: out_port=RESET_VALUE, IRQ_MASK=0, EDGE_CAP=0, sync chain=0, edge-history flop=0, irq=0.
- out_port changes the cycle after the write edge (1-cycle latency).
- Input path: in_port passes through SYNC_STAGES flops, then one history flop. For bit i, edge_det[i] is:
  - EDGE_TYPE 0: sync & ~hist
  - EDGE_TYPE 1: ~sync & hist
  - EDGE_TYPE 2: sync ^ hist
- Post-reset blanking: a counter holds edge_det at 0 for SYNC_STAGES+1 cycles after reset release. This stops inputs already high at reset from producing false rising captures. The counter saturates and then stays idle until the next reset.
- EDGE_CAP[i] is set on edge_det[i]=1 and held until cleared by W1C. If a new edge and a W1C of the same bit occur in the same cycle, the set wins and the bit stays 1.
- Input-to-capture latency: an in_port change is visible in EDGE_CAP SYNC_STAGES+1 cycles later (DATA_IN after SYNC_STAGES cycles).
- irq = |(EDGE_CAP & IRQ_MASK), registered: it asserts the cycle after the qualifying EDGE_CAP/IRQ_MASK state and deasserts the cycle after the last masked bit clears.
- Masking does not block capture: an edge on a masked-off bit still sets EDGE_CAP. Unmasking a pending bit raises irq one cycle later.
- Width rule: WIDTH=32 uses all writedata bits. For WIDTH<32, readdata[31:WIDTH]=0.
- Reset asserted mid-operation: all state returns to reset values immediately and blanking restarts on release.

Test Plan:
- Reset with RESET_VALUE=10'h155, in_port=10'h3FF held high -> out_port=0x155, irq=0, EDGE_CAP reads 0 after blanking (no false rising captures).
- Write DATA_OUT=0x0F0, then OUT_SET=0x00F, then OUT_CLR=0x0C0 -> out_port sequence 0x0F0, 0x0FF, 0x03F, each one cycle after its write; DATA_OUT reads match.
- EDGE_TYPE=0: pulse in_port[3] 0->1, IRQ_MASK=0x008 -> EDGE_CAP=0x008 at cycle SYNC_STAGES+1, irq=1 one cycle later; W1C 0x008 -> EDGE_CAP=0, irq=0 next cycle.
- Same-cycle rising edge on bit 3 and W1C 0x008 -> EDGE_CAP[3] remains 1 and irq stays high.
- IRQ_MASK=0, edge on bit 0 -> EDGE_CAP=0x001, irq=0; then write IRQ_MASK=0x001 -> irq=1 one cycle later.
- EDGE_TYPE=2, WIDTH=32: toggle in_port[31] 1->0 -> EDGE_CAP=0x80000000; read address 6 -> 0; assert reset_n low mid-test -> all registers return to reset values asynchronously.
